// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg: default geometry shared by the adder/subtractor and its users.
package pipelined_addsub_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STAGES = 4;
endpackage

// File: rtl/pipelined_addsub_chunk.sv
// addsub_chunk: CHUNK-bit ripple of full-adder cells, also exposing the carry into its MSB.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic c;
  logic cm;
  always_comb begin
    sum = '0;
    c = cin;
    cm = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      cm = c;
      c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
  end
  assign cout = c;
  assign c_msb_in = cm;
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract, one CHUNK of the carry chain resolved per stage,
// valid/ready on both sides with a combinational backward ready.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;
  logic [STAGES-1:0] v, adv, c_q;
  logic [STAGES-1:0][WIDTH-1:0] x_q, y_q, s_q;
  logic ovf_r;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic v_r, c_r, v_in, c_in, cout, c_msb;
    logic [WIDTH-1:0] x_r, y_r, s_r, x_in, y_in, s_in, s_nx;
    logic [CHUNK-1:0] sum;
    if (k == 0) begin : g_head
      assign v_in = in_valid;
      assign x_in = a;
      assign y_in = b ^ {WIDTH{sub}};
      assign s_in = '0;
      assign c_in = ci ^ sub;
    end else begin : g_body
      assign v_in = v[k-1];
      assign x_in = x_q[k-1];
      assign y_in = y_q[k-1];
      assign s_in = s_q[k-1];
      assign c_in = c_q[k-1];
    end
    // A stage can move whenever any stage downstream of it (or the consumer) has room.
    assign adv[k] = out_ready | ~&v[STAGES-1:k];
    assign v[k] = v_r;
    assign c_q[k] = c_r;
    assign x_q[k] = x_r;
    assign y_q[k] = y_r;
    assign s_q[k] = s_r;
    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x(x_in[k*CHUNK +: CHUNK]),
      .y(y_in[k*CHUNK +: CHUNK]),
      .cin(c_in),
      .sum(sum),
      .cout(cout),
      .c_msb_in(c_msb)
    );
    always_comb begin
      s_nx = s_in;
      s_nx[k*CHUNK +: CHUNK] = sum;
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        x_r <= '0;
        y_r <= '0;
        s_r <= '0;
      end else if (adv[k]) begin
        v_r <= v_in;
        if (v_in) begin
          c_r <= cout;
          x_r <= x_in;
          y_r <= y_in;
          s_r <= s_nx;
        end
      end
    end
    if (k == STAGES - 1) begin : g_tail
      always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_r <= 1'b0;
        else if (adv[k] && v_in) ovf_r <= c_msb ^ cout;
      end
    end
  end
  assign in_ready = adv[0];
  assign out_valid = v[STAGES-1];
  assign s = s_q[STAGES-1];
  assign co = c_q[STAGES-1];
  assign ovf = ovf_r;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed and randomized checks of pipelined_addsub against an arithmetic model.
module tb_pipelined_addsub;
  localparam int W = 32;
  localparam int S = 4;
  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
  logic [W-1:0] a, b, s;
  logic n_in_valid, n_in_ready, n_ci, n_sub, n_out_valid, n_out_ready, n_co, n_ovf;
  logic [7:0] n_a, n_b, n_s;
  int checks = 0;
  int fails = 0;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .ovf(ovf)
  );
  pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready), .a(n_a), .b(n_b),
    .ci(n_ci), .sub(n_sub), .out_valid(n_out_valid), .out_ready(n_out_ready), .s(n_s), .co(n_co), .ovf(n_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic m);
    logic [W-1:0] yy;
    logic [W:0] t;
    logic v;
    yy = m ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c ^ m};
    v = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {v, t};
  endfunction

  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic m);
    logic [7:0] yy;
    logic [8:0] t;
    logic v;
    yy = m ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + {8'd0, c ^ m};
    v = (x[7] == yy[7]) && (t[7] != x[7]);
    return {v, t};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci, input logic tsub,
                        output logic [W-1:0] rs, output logic rco, output logic rovf, output int lat);
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = s; rco = co; rovf = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    n_in_valid = 1'b0; n_out_ready = 1'b0; n_a = '0; n_b = '0; n_ci = 1'b0; n_sub = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({s, co, ovf} !== '0) begin fails++; $display("FAIL reset_outputs got s=%h co=%b ovf=%b want 0", s, co, ovf); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || n_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b/%b want 1/1", in_ready, n_in_ready); end
  endtask

  task automatic test_add_wrap;
    logic [W-1:0] rs; logic rco, rovf; int lat;
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, rs, rco, rovf, lat);
    checks++; if (rs !== 32'h0) begin fails++; $display("FAIL add_wrap_s got %h want 00000000", rs); end
    checks++; if ({rco, rovf} !== 2'b10) begin fails++; $display("FAIL add_wrap_flags got co=%b ovf=%b want co=1 ovf=0", rco, rovf); end
    checks++; if (lat != S) begin fails++; $display("FAIL add_wrap_latency got %0d want %0d", lat, S); end
  endtask

  task automatic test_overflow;
    logic [W-1:0] rs; logic rco, rovf; int lat;
    run_op(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, rs, rco, rovf, lat);
    checks++; if (rs !== 32'h80000000) begin fails++; $display("FAIL ovf_s got %h want 80000000", rs); end
    checks++; if ({rco, rovf} !== 2'b01) begin fails++; $display("FAIL ovf_flags got co=%b ovf=%b want co=0 ovf=1", rco, rovf); end
  endtask

  task automatic test_subtract;
    logic [W-1:0] rs; logic rco, rovf; int lat;
    run_op(32'd5, 32'd7, 1'b0, 1'b1, rs, rco, rovf, lat);
    checks++; if (rs !== 32'hFFFFFFFE) begin fails++; $display("FAIL sub_neg_s got %h want fffffffe", rs); end
    checks++; if ({rco, rovf} !== 2'b00) begin fails++; $display("FAIL sub_neg_flags got co=%b ovf=%b want co=0 ovf=0", rco, rovf); end
    run_op(32'h80000000, 32'd1, 1'b0, 1'b1, rs, rco, rovf, lat);
    checks++; if (rs !== 32'h7FFFFFFF) begin fails++; $display("FAIL sub_ovf_s got %h want 7fffffff", rs); end
    checks++; if ({rco, rovf} !== 2'b11) begin fails++; $display("FAIL sub_ovf_flags got co=%b ovf=%b want co=1 ovf=1", rco, rovf); end
    run_op(32'd9, 32'd3, 1'b1, 1'b1, rs, rco, rovf, lat);
    checks++; if (rs !== 32'd5 || rco !== 1'b1) begin fails++; $display("FAIL sub_borrow_in got s=%h co=%b want s=00000005 co=1", rs, rco); end
  endtask

  task automatic test_back_to_back;
    int idx = 0, got = 0, stall = 0, acc_at_block = -1;
    logic seen = 1'b0, held = 1'b0;
    logic [W-1:0] hs = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      in_valid = idx < 6; a = W'(idx + 1); b = W'(idx + 1); ci = 1'b0; sub = 1'b0;
      if (out_valid && !seen) begin seen = 1'b1; stall = 3; end
      out_ready = stall == 0;
      if (stall > 0) stall--;
      @(negedge clk);
      if (!in_ready && acc_at_block < 0) acc_at_block = idx;
      if (held) begin
        checks++; if (!out_valid || s !== hs) begin fails++; $display("FAIL b2b_hold got v=%b s=%h want v=1 s=%h", out_valid, s, hs); end
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        checks++; if (s !== W'(2 * (got + 1))) begin fails++; $display("FAIL b2b_result got %0d want %0d", s, 2 * (got + 1)); end
        got++;
        held = 1'b0;
      end else begin
        held = out_valid;
        hs = s;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got != 6) begin fails++; $display("FAIL b2b_count got %0d want 6", got); end
    checks++; if (acc_at_block != S) begin fails++; $display("FAIL b2b_full_depth got %0d want %0d", acc_at_block, S); end
  endtask

  task automatic test_random_stream;
    logic [W+1:0] q[$];
    logic [W+1:0] exp, hv;
    int sent = 0, got = 0;
    logic held = 1'b0;
    hv = '0;
    for (int cyc = 0; cyc < 1000 && got < 150; cyc++) begin
      in_valid = (sent < 150) && ($urandom_range(3) != 0);
      a = $urandom; b = $urandom; ci = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
      out_ready = $urandom_range(2) != 0;
      @(negedge clk);
      checks++; if (in_ready !== !(q.size() == S && !out_ready)) begin fails++; $display("FAIL rnd_in_ready got %b occupancy %0d out_ready %b", in_ready, q.size(), out_ready); end
      if (held) begin
        checks++; if (!out_valid || {ovf, co, s} !== hv) begin fails++; $display("FAIL rnd_hold got v=%b %h want v=1 %h", out_valid, {ovf, co, s}, hv); end
      end
      if (in_valid && in_ready) begin q.push_back(model(a, b, ci, sub)); sent++; end
      if (out_valid && out_ready) begin
        exp = q.size() > 0 ? q.pop_front() : 'x;
        checks++; if ({ovf, co, s} !== exp) begin fails++; $display("FAIL rnd_result got %h want %h", {ovf, co, s}, exp); end
        got++;
        held = 1'b0;
      end else begin
        held = out_valid;
        hv = {ovf, co, s};
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got != 150) begin fails++; $display("FAIL rnd_count got %0d want 150", got); end
  endtask

  task automatic test_reset_midflight;
    int t = 0;
    logic seen = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd10; b = 32'd20; ci = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    a = 32'd30; b = 32'd40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
    checks++; if ({s, co, ovf} !== '0) begin fails++; $display("FAIL rst_async_data got s=%h co=%b ovf=%b want 0", s, co, ovf); end
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_ghost_result got %b want 0", seen); end
  endtask

  task automatic test_single_stage;
    logic [9:0] exp;
    n_a = 8'h00; n_b = 8'h00; n_ci = 1'b1; n_sub = 1'b0; n_in_valid = 1'b1; n_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp = model8(n_a, n_b, n_ci, n_sub);
      checks++; if (n_in_ready !== 1'b1) begin fails++; $display("FAIL s1_in_ready got %b want 1", n_in_ready); end
      @(posedge clk); #1;
      checks++; if (n_out_valid !== 1'b1 || {n_ovf, n_co, n_s} !== exp) begin fails++; $display("FAIL s1_result got v=%b %h want v=1 %h", n_out_valid, {n_ovf, n_co, n_s}, exp); end
      if (i == 0) begin
        checks++; if (n_s !== 8'h01 || n_co !== 1'b0) begin fails++; $display("FAIL s1_ci_only got s=%h co=%b want s=01 co=0", n_s, n_co); end
      end
      n_a = 8'($urandom); n_b = 8'($urandom); n_ci = 1'($urandom_range(1)); n_sub = 1'($urandom_range(1));
    end
    n_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (n_out_valid !== 1'b0) begin fails++; $display("FAIL s1_drain got %b want 0", n_out_valid); end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_random_stream();
    test_reset_midflight();
    test_single_stage();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
